ase_mmio_responder: RTL
=======================

Name: ase_mmio_responder

Overview:
- AFU-side responder for host-initiated CCI-P MMIO traffic; the counterpart of the ASE MMIO request generator.
- Decodes the 28-bit config header (index[27:12], len[11:10], rsvd[9], tid[8:0]) and services 32- and 64-bit writes into a local 64-bit CSR file.
- Queues read requests and returns read responses (tid plus 64-bit data) through a valid/ready output stage.
- Flags protocol violations and late responses in sticky error bits.

Parameters:
- NUM_REGS, 16: number of 64-bit CSRs; must be a power of 2 and at least 2.
- RDQ_DEPTH, 4: read-response queue entries; must be a power of 2.
- TIMEOUT, 512: maximum cycles a response may wait at the queue head before a timeout is flagged.
- DEV_ID, 64'h0: read-only value of CSR 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_hdr  in  28  MMIO config header (index, len, tid).
- mmio_wr_valid  in  1  write request strobe.
- mmio_rd_valid  in  1  read request strobe.
- mmio_wrdata  in  64  write data; a 32-bit write uses bits [31:0].
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_tid  out  9  tid echoed from the read request.
- rsp_data  out  64  read data.
- err_flags  out  4  sticky errors: [0] unmapped/misaligned, [1] queue overflow, [2] rd/wr collision, [3] timeout.
- err_clr  in  1  synchronous clear of err_flags.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_tid=0, rsp_data=0, err_flags=0.
  - CSRs 1..NUM_REGS-1 = 0; queue empty; age counter = 0.
  - Takes effect mid-operation: queued responses are discarded, and nothing is emitted until the first cycle after rst_n rises.
- Decode:
  - index is a DWORD address; CSR number = index[log2(NUM_REGS):1]; dword select = index[0].
  - len=0 is a 32-bit access; len=1 is a 64-bit access.
  - len in {2,3}, 64-bit access with index[0]=1, or index >= 2*NUM_REGS: unmapped. Set err_flags[0].
- Writes:
  - Applied at the clock edge where mmio_wr_valid=1.
  - 64-bit write replaces the whole CSR.
  - 32-bit write replaces only the selected dword; the other half is unchanged.
  - Writes to CSR 0 or unmapped addresses are ignored; no error for CSR 0.
- Reads:
  - Data is sampled from the CSR file in the acceptance cycle and stored with tid, so later writes cannot alter an earlier response.
  - 64-bit read returns the full CSR.
  - 32-bit read returns the selected dword replicated in [63:32] and [31:0].
  - Unmapped read is still answered, with data 0 and err_flags[0] set.
- Collision: mmio_wr_valid and mmio_rd_valid high in the same cycle. The write is performed, the read is dropped (no response), and err_flags[2] is set.
- Queue:
  - FIFO of {tid, data}, RDQ_DEPTH entries.
  - A read in cycle N can drive rsp_valid=1 earliest at cycle N+1.
  - Output holds stable while rsp_valid=1 and rsp_ready=0.
  - An entry pops on rsp_valid&rsp_ready.
  - Read arriving while full, with no pop in that cycle: dropped, err_flags[1] set.
  - Read arriving while full with a pop in the same cycle: accepted.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo RDQ_DEPTH.
- Output FSM:
  - IDLE: queue empty, rsp_valid=0. Go to PRESENT when the queue becomes non-empty.
  - PRESENT: rsp_valid=1, head driven.
    - On rsp_ready: pop. Stay in PRESENT if more entries remain, otherwise return to IDLE.
    - Back-to-back responses are possible at one per cycle.
- Age counter:
  - Counts cycles in PRESENT with rsp_ready=0; resets to 0 on every pop.
  - Saturates at TIMEOUT.
  - Reaching TIMEOUT sets err_flags[3]; the response is still delivered afterwards.
- Error flags:
  - Sticky; cleared by err_clr.
  - If a set event and err_clr occur in the same cycle, set wins.

Test Plan:
- Reset, 64-bit write CSR3=64'h1122334455667788 (index=6, len=1), then 64-bit read tid=9'h05 -> at cycle N+1: rsp_valid=1, rsp_tid=5, rsp_data=64'h1122334455667788.
- 32-bit write index=7 data=32'hDEADBEEF, then 32-bit read index=7 -> rsp_data=64'hDEADBEEF_DEADBEEF. A 64-bit read of CSR3 then returns 64'hDEADBEEF55667788.
- Read CSR0 with DEV_ID=64'hA5A5 after writing CSR0=64'hFFFF -> 64'hA5A5, err_flags=0. 64-bit read index=3 -> data 0, err_flags=4'b0001.
- Hold rsp_ready=0 and issue 5 reads with tids 1..5 (RDQ_DEPTH=4) -> tid 5 dropped, err_flags[1]=1. Then release rsp_ready -> tids 1,2,3,4 on consecutive cycles.
- Assert rd and wr together on CSR2 with data 64'h42 -> no response, err_flags[2]=1, a later read of CSR2 returns 64'h42. Pulse err_clr -> err_flags=0.
- Hold rsp_ready=0 for 512 cycles with one queued response -> err_flags[3]=1 and rsp_valid is still 1. Assert rst_n=0 mid-wait -> rsp_valid=0 and err_flags=0 immediately.

Source files
------------

// File: rtl/ase_mmio_responder.sv
// AFU-side CCI-P MMIO responder: decodes host MMIO writes/reads against a local
// 64-bit CSR file and returns read responses through a valid/ready queue.
module ase_mmio_responder #(
   parameter int          NUM_REGS  = 16,
   parameter int          RDQ_DEPTH = 4,
   parameter int          TIMEOUT   = 512,
   parameter logic [63:0] DEV_ID    = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [27:0] cfg_hdr,
   input  logic        mmio_wr_valid,
   input  logic        mmio_rd_valid,
   input  logic [63:0] mmio_wrdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [8:0]  rsp_tid,
   output logic [63:0] rsp_data,
   output logic [3:0]  err_flags,
   input  logic        err_clr
);

   localparam int REG_W = $clog2(NUM_REGS);
   localparam int PTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(RDQ_DEPTH + 1);
   localparam int AGE_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

   // ---------------- header decode ----------------
   logic [15:0]      idx;
   logic [1:0]       len;
   logic [8:0]       tid;
   logic [REG_W-1:0] sel;
   logic             unmapped;
   logic             unused_rsvd;

   assign idx         = cfg_hdr[27:12];
   assign len         = cfg_hdr[11:10];
   assign tid         = cfg_hdr[8:0];
   assign unused_rsvd = cfg_hdr[9];
   assign sel         = idx[REG_W:1];
   assign unmapped    = len[1] || (len[0] && idx[0]) ||
                        (32'(idx) >= 32'(2 * NUM_REGS));

   // ---------------- CSR file ----------------
   logic [63:0] csr [NUM_REGS];
   logic        wr_en;

   assign wr_en = mmio_wr_valid && !unmapped && (sel != '0);

   // NOTE: the CSR file is reset because software may read it before writing;
   // the response queue storage below is not, since it is only seen behind count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) csr[i] <= '0;
      end else if (wr_en) begin
         if (len[0])      csr[sel]        <= mmio_wrdata;
         else if (idx[0]) csr[sel][63:32] <= mmio_wrdata[31:0];
         else             csr[sel][31:0]  <= mmio_wrdata[31:0];
      end
   end

   logic [63:0] rd_word;
   logic [31:0] rd_half;
   logic [63:0] rd_data;

   // NOTE: every always_comb output gets a value on every path, so no latches.
   always_comb begin
      rd_word = (sel == '0) ? DEV_ID : csr[sel];
      rd_half = idx[0] ? rd_word[63:32] : rd_word[31:0];
      rd_data = '0;
      if (!unmapped) rd_data = len[0] ? rd_word : {rd_half, rd_half};
   end

   // ---------------- response queue ----------------
   logic [8:0]       q_tid  [RDQ_DEPTH];
   logic [63:0]      q_data [RDQ_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full, rd_req, push, pop, overflow;

   // A collision drops the read; a full queue only refuses when nothing leaves.
   assign full     = (count == CNT_W'(RDQ_DEPTH));
   assign pop      = rsp_valid && rsp_ready;
   assign rd_req   = mmio_rd_valid && !mmio_wr_valid;
   assign push     = rd_req && (!full || pop);
   assign overflow = rd_req && full && !pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RDQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         q_tid[wr_ptr]  <= tid;
         q_data[wr_ptr] <= rd_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // ---------------- output FSM ----------------
   state_t state, state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (push) state_next = PRESENT;
         PRESENT: if (pop && !push && count == CNT_W'(1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = (state == PRESENT);
      rsp_tid   = rsp_valid ? q_tid[rd_ptr]  : '0;
      rsp_data  = rsp_valid ? q_data[rd_ptr] : '0;
   end

   // ---------------- age counter and errors ----------------
   logic [AGE_W-1:0] age, age_next;
   logic             waiting, timeout_hit;
   logic [3:0]       err_set;

   assign waiting = rsp_valid && !rsp_ready;

   always_comb begin
      age_next = age;
      if (pop)                                     age_next = '0;
      else if (waiting && age != AGE_W'(TIMEOUT))  age_next = age + AGE_W'(1);
   end

   assign timeout_hit = waiting && (age_next == AGE_W'(TIMEOUT));
   assign err_set = {timeout_hit,
                     mmio_wr_valid && mmio_rd_valid,
                     overflow,
                     (mmio_wr_valid || mmio_rd_valid) && unmapped};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age       <= '0;
         err_flags <= '0;
      end else begin
         age       <= age_next;
         err_flags <= (err_clr ? 4'b0 : err_flags) | err_set;
      end
   end

endmodule
